// File: rtl/wb_bram_ctrl.sv
// Wishbone B4 32-bit slave in front of a single-port, byte-writable block RAM.
// Serves classic single transfers and, when WB_BRAM_BURST_EN is defined,
// registered-feedback linear incrementing bursts with read-address prediction.
// Without the macro every transfer is classic regardless of cti/bte.
module wb_bram_ctrl #(
  parameter int MEM_ADR_WIDTH = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_ms_i,
  output logic [31:0] dat_sm_o,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);

  localparam int DEPTH = 1 << MEM_ADR_WIDTH;
  localparam logic [MEM_ADR_WIDTH-1:0] WORD_ONE = {{(MEM_ADR_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]              mem_q [DEPTH];
  logic                     ack_q;
  logic                     ack_d;
  logic [31:0]              dat_sm_q;
  logic                     req;
  logic                     burst;
  logic                     wr_en;
  logic [MEM_ADR_WIDTH-1:0] word;
  logic [MEM_ADR_WIDTH-1:0] rd_word;
  logic                     unused_adr;

  assign req = cyc_i & stb_i;

`ifdef WB_BRAM_BURST_EN
  assign burst = req & (cti_i == 3'b010) & (bte_i == 2'b00);
`else
  logic unused_burst_sig;
  assign unused_burst_sig = ^{cti_i, bte_i};
  assign burst = 1'b0;
`endif

  // Upper address bits and the byte offset alias onto the same words.
  assign unused_adr = ^{adr_i[31:MEM_ADR_WIDTH+2], adr_i[1:0]};
  assign word       = adr_i[MEM_ADR_WIDTH+1:2];

  // During an acked burst beat the master will present the next word, so
  // fetch it now; the index wraps naturally at the memory size.
  assign rd_word = (ack_q & burst) ? (word + WORD_ONE) : word;

  // First request cycle is a wait state; bursts then keep ack asserted.
  assign ack_d = req & (~ack_q | burst);
  assign wr_en = req & we_i & ack_q;

  // Acknowledge register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  // Byte-masked write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) begin
          mem_q[word][8*i +: 8] <= dat_ms_i[8*i +: 8];
        end
      end
    end
  end

  // Synchronous read port; holds its value while the bus is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_sm_q <= 32'h0;
    end else if (req) begin
      dat_sm_q <= mem_q[rd_word];
    end
  end

  assign dat_sm_o = dat_sm_q;
  assign ack_o    = ack_q;
  assign err_o    = 1'b0;
  assign rty_o    = 1'b0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: a bus master drives directed and random classic and
// burst transfers; a memory model plus a per-cycle compare process checks ack
// and read data, and directed literals pin the model.
module tb_wb_bram_ctrl;

  localparam int AW = 11;
  localparam int N  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  always #5 clk = ~clk;

  wb_bram_ctrl #(.MEM_ADR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_ms_i(dat_ms), .dat_sm_o(dat_sm),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .ack_o(ack), .err_o(err), .rty_o(rty)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [N];
  bit          mv [N];
  bit          exp_ack = 1'b0;
  bit          run_cmp = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  // A transfer is complete at the edge where the request is present and ack
  // is already high; bursts (when built in) keep ack high, classic drops it.
  always @(posedge clk) begin
    bit r;
    bit bm;
    r = cyc && stb;
`ifdef WB_BRAM_BURST_EN
    bm = (cti == 3'b010) && (bte == 2'b00);
`else
    bm = 1'b0;
`endif
    if (rst) begin
      exp_ack = 1'b0;
    end else begin
      if (r && we && exp_ack) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mm[widx(adr)][8*b +: 8] = dat_ms[8*b +: 8];
        if (sel == 4'hF) mv[widx(adr)] = 1'b1;
      end
      exp_ack = r && (!exp_ack || bm);
    end
  end

  // Compare process: ack every cycle; read data on every acked read beat.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk(ack == exp_ack, "ack", {31'b0, ack}, {31'b0, exp_ack});
      chk(err == 1'b0 && rty == 1'b0, "err_rty", {30'b0, err, rty}, 32'h0);
      if (exp_ack && cyc && stb && !we && mv[widx(adr)])
        chk(dat_sm == mm[widx(adr)], "rd_data", dat_sm, mm[widx(adr)]);
    end
  end

  // ---------------- bus master ----------------
  logic [31:0] bdata [N];
  logic [31:0] rdata [N];
  logic [3:0]  bsel;
  int          waits_last;
  int          cycles_last;

  task automatic wait_ack(output int w);
    w = 0;
    @(negedge clk);
    while (!ack && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!ack) chk(1'b0, "ack_timeout", 32'(w), 32'd50);
  endtask

  task automatic classic(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    int w;
    adr = a; dat_ms = d; sel = s; we = wr; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    wait_ack(w);
    rd = dat_sm;
    waits_last = w;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst(input bit wr, input logic [31:0] a, input int n,
                       input logic [1:0] b, input int stall_beat);
    int w;
    cycles_last = 0;
    cyc = 1'b1; we = wr; bte = b; sel = bsel;
    for (int i = 0; i < n; i++) begin
      adr    = a + 32'(4 * i);
      cti    = (i == n - 1) ? 3'b111 : 3'b010;
      dat_ms = bdata[i];
      stb    = 1'b1;
      wait_ack(w);
      cycles_last += w + 1;
      rdata[i] = dat_sm;
      @(posedge clk); #1;
      if (i == stall_beat && i != n - 1) begin
        stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    rst = 1'b1; adr = '0; dat_ms = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; cti = 3'b000; bte = 2'b00; bsel = 4'hF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(ack == 1'b0, "reset_ack", {31'b0, ack}, 32'h0);
    chk(dat_sm == 32'h0, "reset_dat", dat_sm, 32'h0);
    chk(err == 1'b0 && rty == 1'b0, "reset_err_rty", {30'b0, err, rty}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmp = 1'b1;

    // Fill the whole memory with known random data.
    for (int i = 0; i < N; i++) bdata[i] = $urandom;
    bsel = 4'hF;
    burst(1'b1, 32'h0, N, 2'b00, -1);

    // Classic write/read.
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    chk(waits_last == 1, "classic_ack_latency", 32'(waits_last), 32'd1);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk(rd == 32'hDEADBEEF, "classic_read", rd, 32'hDEADBEEF);

    // Byte enables.
    classic(1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    classic(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd);
    classic(1'b0, 32'h20, 32'h0, 4'hF, rd);
    chk(rd == 32'h11BB33DD, "byte_enable", rd, 32'h11BB33DD);

    // Incrementing burst write then read back.
    for (int i = 0; i < 8; i++) bdata[i] = 32'(i);
    burst(1'b1, 32'h100, 8, 2'b00, -1);
`ifdef WB_BRAM_BURST_EN
    chk(cycles_last == 9, "burst_wr_cycles", 32'(cycles_last), 32'd9);
`else
    chk(cycles_last == 16, "burst_wr_cycles", 32'(cycles_last), 32'd16);
`endif
    burst(1'b0, 32'h100, 8, 2'b00, -1);
    for (int i = 0; i < 8; i++)
      chk(rdata[i] == 32'(i), "burst_rd", rdata[i], 32'(i));

    // Stalled read burst.
    burst(1'b0, 32'h100, 8, 2'b00, 3);
    for (int i = 0; i < 8; i++)
      chk(rdata[i] == 32'(i), "stall_rd", rdata[i], 32'(i));

    // Wrap and aliasing.
    classic(1'b1, 32'h0, 32'h12345678, 4'hF, rd);
    classic(1'b1, 32'h1FFC, 32'hCAFE0001, 4'hF, rd);
    classic(1'b0, 32'h3FFC, 32'h0, 4'hF, rd);
    chk(rd == 32'hCAFE0001, "alias_read", rd, 32'hCAFE0001);
    burst(1'b0, 32'h1FFC, 2, 2'b00, -1);
    chk(rdata[0] == 32'hCAFE0001, "wrap_beat0", rdata[0], 32'hCAFE0001);
    chk(rdata[1] == 32'h12345678, "wrap_beat1", rdata[1], 32'h12345678);

    // Reset during the ack cycle of a write drops that write.
    classic(1'b0, 32'h40, 32'h0, 4'hF, old);
    adr = 32'h40; dat_ms = ~old; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk(dat_sm == 32'h0, "reset_mid_dat", dat_sm, 32'h0);
    @(posedge clk); #1;
    classic(1'b0, 32'h40, 32'h0, 4'hF, rd);
    chk(rd == old, "reset_mid_nocommit", rd, old);

    // Randomized traffic.
    for (int k = 0; k < 120; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        classic(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
      end else begin
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) bdata[i] = $urandom;
        bsel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        burst(1'($urandom_range(0, 1)), a, n,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
